vector_frame_sequencer: RTL

- Owns the X/Y DAC codes for the vector-display top level.
- Receives a point list as a byte stream from the UART receiver and stores it in an internal point buffer.
- Replays the points in a loop, advancing on strobes from the programmable clock divider, and holds each point for a configurable number of strobes.
- Gives the top level a framed, re-loadable image source in place of a free-running pattern.

---
 rtl/vector_frame_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vector_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : vector_frame_sequencer
// Description : Loads an X/Y point list from a byte stream and replays it
//               on the vector-display DACs, holding each point DWELL ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_frame_sequencer #(
    parameter int         DEPTH    = 32,
    parameter int         DWELL    = 4,
    parameter logic [7:0] HDR_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] xdac,
    output logic [7:0] ydac,
    output logic       loading,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       load_err
);

    localparam int         c_AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] c_DEPTH      = 8'(DEPTH);
    localparam logic [7:0] c_DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR_CNT = 3'd1,
        S_LOAD_X  = 3'd2,
        S_LOAD_Y  = 3'd3,
        S_PLAY    = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_wp;
    logic [7:0] r_idx;
    logic [7:0] r_dwell;
    logic [7:0] r_xdac;
    logic [7:0] r_ydac;
    logic       r_loading;
    logic       r_frame_valid;
    logic       r_frame_done;
    logic       r_load_err;

    logic [7:0] r_mem_x [DEPTH];
    logic [7:0] r_mem_y [DEPTH];

    logic w_hdr;
    logic w_cnt_ok;
    logic w_step;
    logic w_last_pt;
    logic w_wp_last;

    assign w_hdr     = rx_valid && (rx_data == HDR_BYTE);
    assign w_cnt_ok  = (rx_data != 8'd0) && (rx_data <= c_DEPTH);
    assign w_step    = tick && enable;
    assign w_last_pt = (r_idx == (r_cnt - 8'd1));
    assign w_wp_last = (r_wp == (r_cnt - 8'd1));

    // Point buffer: contents are don't-care until a complete frame is loaded.
    always_ff @(posedge clk) begin
        if (rx_valid && (r_state == S_LOAD_X)) begin
            r_mem_x[r_wp[c_AW-1:0]] <= rx_data;
        end
        if (rx_valid && (r_state == S_LOAD_Y)) begin
            r_mem_y[r_wp[c_AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_wp          <= 8'd0;
            r_idx         <= 8'd0;
            r_dwell       <= 8'd0;
            r_xdac        <= 8'h80;
            r_ydac        <= 8'h80;
            r_loading     <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_load_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hdr) begin
                        r_state   <= S_HDR_CNT;
                        r_loading <= 1'b1;
                    end
                end
                S_HDR_CNT: begin
                    if (rx_valid) begin
                        r_frame_valid <= 1'b0;
                        if (w_cnt_ok) begin
                            r_cnt   <= rx_data;
                            r_wp    <= 8'd0;
                            r_state <= S_LOAD_X;
                        end else begin
                            r_load_err <= 1'b1;
                            r_loading  <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_LOAD_X: begin
                    if (rx_valid) begin
                        r_state <= S_LOAD_Y;
                    end
                end
                S_LOAD_Y: begin
                    if (rx_valid) begin
                        if (w_wp_last) begin
                            r_frame_valid <= 1'b1;
                            r_idx         <= 8'd0;
                            r_dwell       <= 8'd0;
                            r_loading     <= 1'b0;
                            r_state       <= S_PLAY;
                        end else begin
                            r_wp    <= r_wp + 8'd1;
                            r_state <= S_LOAD_X;
                        end
                    end
                end
                S_PLAY: begin
                    // Synchronous buffer read: DACs follow the index one cycle late.
                    r_xdac <= r_mem_x[r_idx[c_AW-1:0]];
                    r_ydac <= r_mem_y[r_idx[c_AW-1:0]];
                    if (w_hdr) begin
                        r_state   <= S_HDR_CNT;
                        r_loading <= 1'b1;
                    end else if (w_step) begin
                        if (r_dwell == c_DWELL_LAST) begin
                            r_dwell <= 8'd0;
                            if (w_last_pt) begin
                                r_idx        <= 8'd0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_idx <= r_idx + 8'd1;
                            end
                        end else begin
                            r_dwell <= r_dwell + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_loading <= 1'b0;
                end
            endcase
        end
    end

    assign xdac        = r_xdac;
    assign ydac        = r_ydac;
    assign loading     = r_loading;
    assign frame_valid = r_frame_valid;
    assign frame_done  = r_frame_done;
    assign load_err    = r_load_err;

endmodule
`default_nettype wire
